systolic_array_ctrl: RTL and testbench
======================================

SYSTOLIC_ARRAY_CTRL -- requirements
Module: systolic_array_ctrl

Interface
REQ-001 The parameter list SHALL be: ARRWIDTH, default 8, number of array columns; ARRHEIGHT, default 8, number of array rows; CNTWIDTH, default 16, width of the vector count.
REQ-002 The block SHALL have one clock and one reset, and they SHALL be listed first: clk, input, 1, global clock, active on the positive edge; reset_n, input, 1, global reset, asynchronous and active-low.
REQ-003 Ports, one per line:
- start  input  1  single-cycle job request; honoured only in IDLE.
- num_vectors  input  CNTWIDTH  activation vectors in the job; sampled on the start cycle.
- w_valid  input  1  weight row present on the weight bus.
- w_ready  output  1  controller accepts the weight row.
- a_valid  input  1  activation vector present on the activation bus.
- a_ready  output  1  controller accepts the activation vector.
- sa_mode  output  1  array mode: 0 = weight shift, 1 = compute shift.
- sa_a_zero  output  1  1 = drive the array activation input with zeros (bubble or drain).
- ps_valid  output  1  the array partial-sum output word belongs to an accepted vector.
- busy  output  1  controller is not in IDLE.
- done  output  1  one-cycle pulse when the job ends.
- err  output  1  sticky flag for weight-load underrun; cleared by start.

Function
REQ-004 The state machine SHALL have the states IDLE, LOAD_W, COMPUTE, DRAIN and FINISH, encoded as one-hot or binary.
REQ-005 IDLE: when start=1, the controller SHALL latch num_vectors, clear err and go to LOAD_W on the next cycle.
REQ-006 LOAD_W: sa_mode=0 and w_ready=1; each cycle with w_valid=1 SHALL increment the row counter.
REQ-007 After ARRHEIGHT accepted rows, LOAD_W SHALL go to COMPUTE, or to FINISH if the latched num_vectors=0.
REQ-008 If w_valid=0 in any LOAD_W cycle, the controller SHALL set err=1 and go to FINISH, since weight rows must be gap-free.
REQ-009 COMPUTE: sa_mode=1 and a_ready=1; a cycle with a_valid=1 SHALL accept one vector (sa_a_zero=0) and increment the vector counter.
REQ-010 A COMPUTE cycle with a_valid=0 SHALL insert a bubble (sa_a_zero=1); the array still shifts, and the bubble is not counted.
REQ-011 When the accepted count reaches the latched num_vectors, COMPUTE SHALL go to DRAIN on the next cycle, with a_ready=0 from that cycle on.
REQ-012 DRAIN: sa_mode=1, sa_a_zero=1 and a_ready=0 for exactly LAT = ARRHEIGHT+ARRWIDTH+1 cycles; DRAIN SHALL then go to FINISH.
REQ-013 FINISH: done=1 for one cycle; the next state SHALL be IDLE.
REQ-014 ps_valid SHALL be produced by a LAT-deep valid shift register clocked when sa_mode=1.
- Its input is the accept strobe (a_valid and a_ready).
- ps_valid therefore rises exactly LAT compute cycles after each accepted vector; bubbles produce ps_valid=0.
REQ-015 Vector counts SHALL be unsigned CNTWIDTH-bit values; the counter compares for equality, so it never wraps within a job.
REQ-016 In IDLE and FINISH: sa_mode=0, sa_a_zero=1, w_ready=0 and a_ready=0.
REQ-017 start asserted outside IDLE SHALL be ignored.
REQ-018 busy SHALL be 1 in every state except IDLE.

Reset
REQ-019 Asserting reset_n=0 SHALL, asynchronously:
- force IDLE and clear all counters and the valid shift register;
- drive outputs to sa_mode=0, sa_a_zero=1, w_ready=0, a_ready=0, ps_valid=0, busy=0, done=0, err=0.
REQ-020 Reset asserted mid-job SHALL abandon the job with no done pulse; after release the controller is in IDLE.

Configuration
REQ-021 When the macro SA_CTRL_PERF_CNT_EN is defined, the block SHALL add two outputs and their counters:
- cyc_cnt (32 bits): counts busy cycles of the current job.
- bub_cnt (32 bits): counts bubbles of the current job.
- Both clear on an accepted start and on reset, and hold their value in IDLE.
REQ-022 When SA_CTRL_PERF_CNT_EN is undefined, those ports and counters SHALL be absent; all other behaviour is identical.

Verification (ARRWIDTH=ARRHEIGHT=4, LAT=9)
REQ-023 start with num_vectors=3, four gap-free w_valid beats, then a_valid held high -> exactly 3 a accepts, then 9 DRAIN cycles, done one cycle later; ps_valid high for 3 consecutive cycles, the first 9 compute cycles after the first accept.
REQ-024 num_vectors=4 with a_valid low for 2 cycles between vectors 2 and 3 -> 2 bubbles with sa_a_zero=1, ps_valid pattern 1,1,0,0,1,1; bub_cnt=2 when the macro is defined.
REQ-025 w_valid drops on the third LOAD_W beat -> err=1, done pulse, return to IDLE, no COMPUTE cycles.
REQ-026 num_vectors=0 -> four LOAD_W beats, then FINISH and done with no sa_mode=1 cycle; start pulsed during busy -> ignored, no second job.
REQ-027 reset_n pulsed low in mid-COMPUTE -> all outputs take their reset values immediately, no done pulse, ps_valid=0; a new start afterwards runs a clean job.

Source files
------------

// File: rtl/systolic_array_ctrl.sv
// Sequencer for a weight-stationary systolic array: weight load, compute, drain, done.
// Optional perf counters (cyc_cnt, bub_cnt) are built when SA_CTRL_PERF_CNT_EN is defined.
module systolic_array_ctrl #(
    parameter int ARRWIDTH  = 8,
    parameter int ARRHEIGHT = 8,
    parameter int CNTWIDTH  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [CNTWIDTH-1:0] num_vectors,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic                a_valid,
    output logic                a_ready,
    output logic                sa_mode,
    output logic                sa_a_zero,
    output logic                ps_valid,
    output logic                busy,
    output logic                done,
    output logic                err
`ifdef SA_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]         cyc_cnt,
    output logic [31:0]         bub_cnt
`endif
);

    localparam int LAT = ARRHEIGHT + ARRWIDTH + 1;
    localparam int RW  = (ARRHEIGHT > 1) ? $clog2(ARRHEIGHT) : 1;
    localparam int DW  = $clog2(LAT);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ARRHEIGHT - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_COMPUTE,
        ST_DRAIN,
        ST_FINISH
    } state_e;

    state_e              state_q, state_d;
    logic [CNTWIDTH-1:0] nvec_q, nvec_d;
    logic [CNTWIDTH-1:0] vec_q, vec_d;
    logic [RW-1:0]       row_q, row_d;
    logic [DW-1:0]       drn_q, drn_d;
    logic                err_q, err_d;
    logic [LAT-1:0]      vld_q;
    logic                accept;

    always_comb begin
        // NOTE: every next-state value and output is defaulted first so no latch is inferred.
        state_d   = state_q;
        nvec_d    = nvec_q;
        vec_d     = vec_q;
        row_d     = row_q;
        drn_d     = drn_q;
        err_d     = err_q;
        w_ready   = 1'b0;
        a_ready   = 1'b0;
        sa_mode   = 1'b0;
        sa_a_zero = 1'b1;
        done      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    nvec_d  = num_vectors;
                    err_d   = 1'b0;
                    vec_d   = '0;
                    row_d   = '0;
                    drn_d   = '0;
                    state_d = ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    row_d = row_q + RW'(1);
                    if (row_q == ROW_LAST)
                        state_d = (nvec_q == '0) ? ST_FINISH : ST_COMPUTE;
                end else begin
                    // Weight rows must arrive back to back; a gap aborts the job.
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_COMPUTE: begin
                sa_mode   = 1'b1;
                a_ready   = 1'b1;
                sa_a_zero = ~a_valid;
                if (a_valid) begin
                    vec_d = vec_q + CNTWIDTH'(1);
                    if (vec_q + CNTWIDTH'(1) == nvec_q)
                        state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                sa_mode = 1'b1;
                drn_d   = drn_q + DW'(1);
                if (drn_q == DRAIN_LAST)
                    state_d = ST_FINISH;
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_n) begin
            state_q <= ST_IDLE;
            nvec_q  <= '0;
            vec_q   <= '0;
            row_q   <= '0;
            drn_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nvec_q  <= nvec_d;
            vec_q   <= vec_d;
            row_q   <= row_d;
            drn_q   <= drn_d;
            err_q   <= err_d;
        end
    end

    assign accept = a_valid & a_ready;

    // Valid pipe mirrors the array latency; it advances only while the array shifts.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: this pipe is plain flops, so it is reset to drop in-flight valids on abort.
        if (!reset_n)
            vld_q <= '0;
        else if (sa_mode)
            vld_q <= {vld_q[LAT-2:0], accept};
    end

    assign ps_valid = vld_q[LAT-1];
    assign busy     = (state_q != ST_IDLE);
    assign err      = err_q;

`ifdef SA_CTRL_PERF_CNT_EN
    logic [31:0] cyc_q;
    logic [31:0] bub_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q <= '0;
            bub_q <= '0;
        end else if (state_q == ST_IDLE) begin
            if (start) begin
                cyc_q <= '0;
                bub_q <= '0;
            end
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (state_q == ST_COMPUTE && !a_valid)
                bub_q <= bub_q + 32'd1;
        end
    end

    assign cyc_cnt = cyc_q;
    assign bub_cnt = bub_q;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed self-checking bench for systolic_array_ctrl with a 4x4 array (LAT = 9).
// Perf-counter checks are compiled in when SA_CTRL_PERF_CNT_EN is defined.
module tb_systolic_array_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [CW-1:0] num_vectors;
    logic          w_valid;
    logic          w_ready;
    logic          a_valid;
    logic          a_ready;
    logic          sa_mode;
    logic          sa_a_zero;
    logic          ps_valid;
    logic          busy;
    logic          done;
    logic          err;
`ifdef SA_CTRL_PERF_CNT_EN
    logic [31:0]   cyc_cnt;
    logic [31:0]   bub_cnt;
`endif

    systolic_array_ctrl #(
        .ARRWIDTH (W),
        .ARRHEIGHT(H),
        .CNTWIDTH (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .num_vectors(num_vectors),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .sa_mode    (sa_mode),
        .sa_a_zero  (sa_a_zero),
        .ps_valid   (ps_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef SA_CTRL_PERF_CNT_EN
        ,
        .cyc_cnt    (cyc_cnt),
        .bub_cnt    (bub_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          r_wbeats, r_acc, r_bub, r_drain, r_sa, r_done_idx;
    logic [31:0] r_ps_mask;
    logic        r_err, r_fin_ok;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one job from IDLE (entered at posedge+1) until the done cycle, recording
    // per-cycle observations. wpat/apat give w_valid/a_valid per LOAD_W/COMPUTE cycle.
    task automatic run_job(input logic [CW-1:0] nv, input logic [31:0] wpat,
                           input logic [31:0] apat, input int restart_at);
        int widx = 0, cidx = 0, sidx = 0, bidx = 0;
        bit fin = 0;
        r_wbeats = 0; r_acc = 0; r_bub = 0; r_drain = 0; r_sa = 0;
        r_done_idx = -1; r_ps_mask = '0; r_err = 1'b0; r_fin_ok = 1'b0;
        start = 1'b1; num_vectors = nv; w_valid = 1'b0; a_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (!fin && bidx < 100) begin
            start       = (bidx == restart_at);
            num_vectors = 16'd5;
            w_valid     = (widx < 32) ? wpat[widx] : 1'b0;
            a_valid     = (cidx < 32) ? apat[cidx] : 1'b0;
            #1;
            if (w_ready) begin
                if (w_valid) r_wbeats++;
                widx++;
            end
            if (a_ready) begin
                if (a_valid) r_acc++;
                else if (sa_a_zero) r_bub++;
                cidx++;
            end
            if (sa_mode) begin
                if (!a_ready && sa_a_zero) r_drain++;
                if (ps_valid && sidx < 32) r_ps_mask[sidx] = 1'b1;
                sidx++;
            end
            if (done) begin
                r_done_idx = bidx;
                r_err      = err;
                r_fin_ok   = !sa_mode && sa_a_zero && !w_ready && !a_ready && busy;
                fin        = 1;
            end else begin
                bidx++;
                @(posedge clk); #1;
            end
        end
        r_sa  = sidx;
        start = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
        if (!fin) check("job_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sa_mode"},   32'(sa_mode),   32'd0);
        check({tag, "_sa_a_zero"}, 32'(sa_a_zero), 32'd1);
        check({tag, "_w_ready"},   32'(w_ready),   32'd0);
        check({tag, "_a_ready"},   32'(a_ready),   32'd0);
        check({tag, "_ps_valid"},  32'(ps_valid),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_err"},       32'(err),       32'd0);
    endtask

    initial begin
        int busy_seen;
        reset_n = 1'b0; start = 1'b0; num_vectors = '0; w_valid = 1'b0; a_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Job 1: 3 vectors, no bubbles.
        run_job(16'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        check("j1_wbeats", r_wbeats, 4);
        check("j1_accepts", r_acc, 3);
        check("j1_bubbles", r_bub, 0);
        check("j1_drain", r_drain, 9);
        check("j1_sa_cycles", r_sa, 12);
        check("j1_ps_mask", r_ps_mask, 32'h0000_0E00);
        check("j1_done_idx", r_done_idx, 16);
        check("j1_err", 32'(r_err), 0);
        check("j1_finish_outputs", 32'(r_fin_ok), 1);
        @(posedge clk); #1;
        check("j1_idle_busy", 32'(busy), 0);
`ifdef SA_CTRL_PERF_CNT_EN
        check("j1_cyc_cnt", cyc_cnt, 17);
        check("j1_bub_cnt", bub_cnt, 0);
`endif

        // Job 2: 4 vectors with two bubbles between vectors 2 and 3.
        run_job(16'd4, 32'hFFFF_FFFF, 32'h0000_0033, -1);
        check("j2_accepts", r_acc, 4);
        check("j2_bubbles", r_bub, 2);
        check("j2_drain", r_drain, 9);
        check("j2_sa_cycles", r_sa, 15);
        check("j2_ps_mask", r_ps_mask, 32'h0000_6600);
        check("j2_done_idx", r_done_idx, 19);
        @(posedge clk); #1;
`ifdef SA_CTRL_PERF_CNT_EN
        check("j2_cyc_cnt", cyc_cnt, 20);
        check("j2_bub_cnt", bub_cnt, 2);
`endif

        // Job 3: weight underrun on the third beat.
        run_job(16'd2, 32'h0000_0003, 32'hFFFF_FFFF, -1);
        check("j3_wbeats", r_wbeats, 2);
        check("j3_sa_cycles", r_sa, 0);
        check("j3_accepts", r_acc, 0);
        check("j3_done_idx", r_done_idx, 3);
        check("j3_err", 32'(r_err), 1);
        @(posedge clk); #1;
        check("j3_idle_busy", 32'(busy), 0);
        check("j3_err_sticky", 32'(err), 1);
`ifdef SA_CTRL_PERF_CNT_EN
        check("j3_cyc_cnt", cyc_cnt, 4);
`endif

        // Job 4: zero vectors, plus a start pulse during LOAD_W that must be ignored.
        run_job(16'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        check("j4_wbeats", r_wbeats, 4);
        check("j4_sa_cycles", r_sa, 0);
        check("j4_done_idx", r_done_idx, 4);
        check("j4_err_cleared", 32'(r_err), 0);
        busy_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (busy) busy_seen++;
        end
        check("j4_no_second_job", busy_seen, 0);

        // Reset in mid-COMPUTE once ps_valid is already flowing.
        start = 1'b1; num_vectors = 16'd20;
        @(posedge clk); #1;
        start = 1'b0; w_valid = 1'b1; a_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_pre_sa_mode", 32'(sa_mode), 1);
        repeat (10) @(posedge clk);
        #1;
        check("rst_pre_ps_valid", 32'(ps_valid), 1);
        check("rst_pre_a_ready", 32'(a_ready), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        busy_seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done || busy) busy_seen++;
        end
        check("midrst_held", busy_seen, 0);
        reset_n = 1'b1; w_valid = 1'b0; a_valid = 1'b0;
        @(posedge clk); #1;
        check("postrst_idle", 32'(busy), 0);

        // Clean job after the abort.
        run_job(16'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        check("j6_accepts", r_acc, 2);
        check("j6_sa_cycles", r_sa, 11);
        check("j6_ps_mask", r_ps_mask, 32'h0000_0600);
        check("j6_done_idx", r_done_idx, 15);
        check("j6_drain", r_drain, 9);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
